mul_pipe_hs: RTL and testbench

//  Parametrised W x W multiplier for the MD datapath, pipelined with valid/ready handshake.

---
 rtl/mul_pipe_hs.sv | 77 +++++++
 tb/tb_mul_pipe_hs.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mul_pipe_hs.sv
// mul_pipe_hs: two-stage W x W signed/unsigned multiplier with valid/ready handshake (in_* request, out_* result, busy)
module mul_pipe_hs #(
  parameter int W = 64,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [W-1:0]     in_x,
  input  logic [W-1:0]     in_y,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_p,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  localparam int H = W / 2;
  logic             v1_q, v2_q, neg_q, neg_d, s1_en, s2_en, accept;
  logic [W-1:0]     mx, my;
  logic [W-1:0]     pp_ll_d, pp_lh_d, pp_hl_d, pp_hh_d;
  logic [W-1:0]     pp_ll_q, pp_lh_q, pp_hl_q, pp_hh_q;
  logic [TAG_W-1:0] tag1_q, tag2_q;
  logic [W:0]       mid;
  logic [2*W-1:0]   s, p_d, p_q;
  always_comb begin
    s2_en = !v2_q | out_ready;
    s1_en = !v1_q | s2_en;
    accept = in_valid & s1_en;
    mx = (in_signed & in_x[W-1]) ? -in_x : in_x;
    my = (in_signed & in_y[W-1]) ? -in_y : in_y;
    neg_d = in_signed & (in_x[W-1] ^ in_y[W-1]);
    pp_ll_d = W'(mx[H-1:0]) * W'(my[H-1:0]);
    pp_lh_d = W'(mx[H-1:0]) * W'(my[W-1:H]);
    pp_hl_d = W'(mx[W-1:H]) * W'(my[H-1:0]);
    pp_hh_d = W'(mx[W-1:H]) * W'(my[W-1:H]);
    mid = {1'b0, pp_lh_q} + {1'b0, pp_hl_q};
    s = {pp_hh_q, {W{1'b0}}} + ({{(W-1){1'b0}}, mid} << H) + {{W{1'b0}}, pp_ll_q};
    p_d = neg_q ? -s : s;
  end
  assign in_ready = s1_en;
  assign out_valid = v2_q;
  assign busy = v1_q | v2_q;
  assign out_p = p_q;
  assign out_tag = tag2_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      neg_q <= 1'b0;
      pp_ll_q <= '0;
      pp_lh_q <= '0;
      pp_hl_q <= '0;
      pp_hh_q <= '0;
      tag1_q <= '0;
      tag2_q <= '0;
      p_q <= '0;
    end else begin
      if (s1_en) v1_q <= accept;
      if (accept) begin
        neg_q <= neg_d;
        pp_ll_q <= pp_ll_d;
        pp_lh_q <= pp_lh_d;
        pp_hl_q <= pp_hl_d;
        pp_hh_q <= pp_hh_d;
        tag1_q <= in_tag;
      end
      if (s2_en) v2_q <= v1_q;
      if (s2_en & v1_q) begin
        p_q <= p_d;
        tag2_q <= tag1_q;
      end
    end
  end
endmodule

// File: tb/tb_mul_pipe_hs.sv
// tb_mul_pipe_hs: random and directed checks of mul_pipe_hs at W=64 and W=16 against an arithmetic scoreboard
module tb_mul_pipe_hs;
  logic         clk = 0, reset = 1, iv = 0, sg = 0, ordy = 1;
  logic [63:0]  x = '0, y = '0;
  logic [3:0]   tg = '0;
  logic         ir64, ov64, b64, ir16, ov16, b16;
  logic [127:0] p64;
  logic [31:0]  p16;
  logic [3:0]   t64, t16;
  int           nchk = 0, nerr = 0, cyc = 0;
  typedef struct {
    logic [127:0] p64;
    logic [31:0]  p16;
    logic [3:0]   tag;
    int           acc;
  } exp_t;
  exp_t q[$];

  mul_pipe_hs #(.W(64), .TAG_W(4)) u64 (
    .clk(clk), .reset(reset), .in_valid(iv), .in_ready(ir64), .in_signed(sg),
    .in_x(x), .in_y(y), .in_tag(tg), .out_valid(ov64), .out_ready(ordy),
    .out_p(p64), .out_tag(t64), .busy(b64)
  );
  mul_pipe_hs #(.W(16), .TAG_W(4)) u16 (
    .clk(clk), .reset(reset), .in_valid(iv), .in_ready(ir16), .in_signed(sg),
    .in_x(x[15:0]), .in_y(y[15:0]), .in_tag(tg), .out_valid(ov16), .out_ready(ordy),
    .out_p(p16), .out_tag(t16), .busy(b16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] ref_mul(input logic s, input logic [63:0] a_in, input logic [63:0] b_in, input int w);
    logic [127:0] a, b, mk;
    a = {64'b0, a_in} & ((128'(1) << w) - 1);
    b = {64'b0, b_in} & ((128'(1) << w) - 1);
    if (s && a[w-1]) a = a - (128'(1) << w);
    if (s && b[w-1]) b = b - (128'(1) << w);
    mk = (w == 64) ? '1 : ((128'(1) << (2 * w)) - 1);
    return (a * b) & mk;
  endfunction

  task automatic step(input logic v, input logic s, input logic [63:0] xx, input logic [63:0] yy,
                      input logic [3:0] t, input logic r);
    logic er, eo;
    exp_t e;
    iv = v; sg = s; x = xx; y = yy; tg = t; ordy = r;
    @(negedge clk);
    er = !(q.size() == 2 && !r);
    eo = q.size() > 0 && cyc >= q[0].acc + 2;
    chk("in_ready64", 128'(ir64), 128'(er));
    chk("in_ready16", 128'(ir16), 128'(er));
    chk("out_valid64", 128'(ov64), 128'(eo));
    chk("out_valid16", 128'(ov16), 128'(eo));
    chk("busy64", 128'(b64), 128'(q.size() > 0));
    chk("busy16", 128'(b16), 128'(q.size() > 0));
    if (eo) begin
      chk("p64", p64, q[0].p64);
      chk("tag64", 128'(t64), 128'(q[0].tag));
      chk("p16", 128'(p16), 128'(q[0].p16));
      chk("tag16", 128'(t16), 128'(q[0].tag));
    end
    if (eo && r) void'(q.pop_front());
    if (v && er) begin
      e.p64 = ref_mul(s, xx, yy, 64);
      e.p16 = 32'(ref_mul(s, xx, yy, 16));
      e.tag = t;
      e.acc = cyc;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h0000_0000_0000_8000;
      4: return 64'd1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic directed(input logic s, input logic [63:0] xx, input logic [63:0] yy,
                          input logic [3:0] t, input logic [127:0] exp, input string nm);
    step(1, s, xx, yy, t, 1);
    step(0, 0, '0, '0, 0, 1);
    chk({nm, "_valid"}, 128'(ov64), 128'(1));
    chk({nm, "_p"}, p64, exp);
    chk({nm, "_tag"}, 128'(t64), 128'(t));
  endtask

  initial begin
    #12;
    chk("rst_valid", 128'(ov64), 0);
    chk("rst_busy", 128'(b64), 0);
    chk("rst_p", p64, 0);
    chk("rst_tag", 128'(t64), 0);
    chk("rst_p16", 128'(p16), 0);
    @(negedge clk);
    reset = 0;
    @(posedge clk);
    #1;
    directed(0, '1, '1, 3, 128'hFFFFFFFFFFFFFFFE_0000000000000001, "uns_max");
    directed(1, '1, 64'd5, 4, 128'hFFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFB, "sgn_m1x5");
    directed(1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5,
             128'h4000_0000_0000_0000_0000_0000_0000_0000, "sgn_minmin");
    directed(0, 64'h8000_0000_0000_0000, 64'd2, 6, 128'h1_0000_0000_0000_0000, "uns_min2");
    directed(1, 64'h8000_0000_0000_0000, 64'd1, 7, 128'hFFFFFFFFFFFFFFFF_8000000000000000, "sgn_minx1");
    step(0, 0, '0, '0, 0, 1);
    for (int i = 0; i < 8; i++) step(1, i[0], pick(), pick(), 4'(i), 1);
    for (int i = 0; i < 3; i++) step(0, 0, '0, '0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 1, pick(), pick(), 4'(8 + i), 0);
    chk("stall_depth", 128'(q.size()), 2);
    for (int i = 0; i < 4; i++) step(0, 0, '0, '0, 0, 1);
    chk("stall_drain", 128'(q.size()), 0);
    for (int i = 0; i < 6; i++) step(1, 0, pick(), pick(), 4'(i), 1'($urandom_range(0, 1)));
    #2;
    reset = 1;
    #1;
    chk("arst_valid", 128'(ov64), 0);
    chk("arst_busy", 128'(b64), 0);
    chk("arst_p", p64, 0);
    chk("arst_valid16", 128'(ov16), 0);
    chk("arst_p16", 128'(p16), 0);
    q.delete();
    iv = 0;
    @(posedge clk);
    #3;
    reset = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) step(0, 0, '0, '0, 0, 1);
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick(), pick(),
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
    for (int i = 0; i < 4; i++) step(0, 0, '0, '0, 0, 1);
    chk("final_drain", 128'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
